// File: rtl/rom_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_pkg
// Brief    : Shared FSM state type and output-buffer sizing for rom_stream_reader.
// Revision : 1.0
// ============================================================================
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH    = 2;
  localparam int PTR_WIDTH    = $clog2(BUF_DEPTH);
  localparam int OCC_WIDTH    = $clog2(BUF_DEPTH + 1);
  // One spare bit so occupancy + in-flight cannot wrap when summed.
  localparam int CREDIT_WIDTH = OCC_WIDTH + 1;

endpackage
`default_nettype wire

// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader_if
// Brief    : Command, ROM-side and stream-side signals of rom_stream_reader.
// Revision : 1.0
// ============================================================================
interface rom_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   length_i;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;
  logic                  busy_o;
  logic                  done_o;

  // master: the reader itself; slave: the surrounding ROM, controller and consumer
  modport master (
    input  start_i, base_addr_i, length_i, rom_data_i, ready_i,
    output rom_addr_o, data_o, valid_o, last_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, length_i, rom_data_i, ready_i,
    input  rom_addr_o, data_o, valid_o, last_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/rom_stream_reader_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo2
// Brief    : 2-entry synchronous FIFO; head entry is presented combinationally.
// Revision : 1.0
// ============================================================================
module stream_fifo2
  import rom_stream_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [OCC_WIDTH-1:0] occ_o
);

  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic [WIDTH-1:0]     mem_d [BUF_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end
    count_d = count_q + OCC_WIDTH'(push_i) - OCC_WIDTH'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = count_q;

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader
// Brief    : Walks a ROM address window and streams the words out valid/ready.
// Revision : 1.0
// ============================================================================
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_stream_reader_if.master bus
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  prime_q, prime_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]    w_head;
  logic [OCC_WIDTH-1:0]   w_occ;
  logic                   w_valid;
  logic                   w_pop;
  logic [CREDIT_WIDTH-1:0] w_credit;
  logic                   w_issue;

  stream_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, bus.rom_data_i}),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .occ_o       (w_occ)
  );

  assign w_valid  = (w_occ != '0);
  assign w_pop    = w_valid & bus.ready_i;
  // Slots the buffer will still owe after this edge: stored words minus the
  // one leaving plus the one arriving from the ROM.
  assign w_credit = CREDIT_WIDTH'(w_occ) - CREDIT_WIDTH'(w_pop) + CREDIT_WIDTH'(inflight_q);
  assign w_issue  = (state_q == RUN) & ~prime_q & (remaining_q != '0)
                  & (w_credit < CREDIT_WIDTH'(BUF_DEPTH));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    prime_d         = 1'b0;
    inflight_d      = w_issue;
    inflight_last_d = w_issue & (remaining_q == CNT_WIDTH'(1));
    busy_d          = busy_q;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.length_i != '0) begin
            // Base sits on the ROM address for one cycle before the first issue.
            addr_d      = bus.base_addr_i;
            remaining_d = bus.length_i;
            prime_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_head[DATA_WIDTH]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      prime_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      prime_q         <= prime_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.rom_addr_o = addr_q;
  assign bus.data_o     = w_head[DATA_WIDTH-1:0];
  assign bus.valid_o    = w_valid;
  assign bus.last_o     = w_valid & w_head[DATA_WIDTH];
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_stream_reader
// Brief    : Table-driven bench with a ROM model and an expected-beat queue.
// Revision : 1.0
// ============================================================================
module tb_rom_stream_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rom_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered-read ROM whose word i is 0xA0 + i.
  always @(posedge clk) bus.rom_data_i <= 8'hA0 + {4'h0, bus.rom_addr_o};

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            inject;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_final;
    int            exp_beats;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            beat_cnt = 0;
  int            done_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [DW-1:0] first_data = '0;
  logic [DW-1:0] final_data = '0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;
  bit            chk_done_next = 1'b0;
  logic [11:0]   rdy_pat = 12'b1010_1010_1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: pops the scoreboard on every handshake, checks stall hold.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend     = 1'b0;
      chk_done_next = 1'b0;
    end else begin
      if (chk_done_next)
        check("done_after_last", 32'({bus.done_o, bus.busy_o}), 32'h2);
      chk_done_next = 1'b0;
      if (bus.done_o) done_cnt++;
      if (hold_pend)
        check("stall_hold", 32'({bus.valid_o, bus.last_o, bus.data_o}),
              32'({1'b1, hold_last, hold_data}));
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h, want no beat", bus.data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 32'({bus.last_o, bus.data_o}), 32'({mon_e.last, mon_e.data}));
          if (beat_cnt == 0) begin
            first_data = bus.data_o;
            first_cyc  = cyc;
          end
          last_cyc = cyc;
          if (bus.last_o) final_data = bus.data_o;
          beat_cnt++;
          chk_done_next = bus.last_o;
        end
      end
      hold_pend = bus.valid_o && !bus.ready_i;
      hold_data = bus.data_o;
      hold_last = bus.last_o;
    end
  end

  task automatic drive_ready(input int mode, input int k);
    bus.ready_i = (mode == 0) ? 1'b1 : rdy_pat[k % 12];
  endtask

  task automatic push_expected(input logic [AW-1:0] base, input logic [AW:0] len);
    beat_t         b;
    logic [AW-1:0] a;
    for (int k = 0; k < int'(len); k++) begin
      a      = base + AW'(k);
      b.data = 8'hA0 + {4'h0, a};
      b.last = (k == int'(len) - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_cmd(input logic [AW-1:0] base, input logic [AW:0] len);
    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.length_i    = len;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.length_i    = '0;
  endtask

  task automatic run_burst(input vec_t v);
    int c;
    push_expected(v.base, v.len);
    beat_cnt = 0;
    done_cnt = 0;
    drive_ready(v.mode, 0);
    start_cmd(v.base, v.len);
    c = 0;
    drive_ready(v.mode, 0);
    if (v.len == 0)
      check("zero_len_done", 32'({bus.done_o, bus.busy_o}), 32'h2);
    else
      check("start_busy", 32'(bus.busy_o), 32'h1);
    while ((c < 4 || exp_q.size() != 0 || bus.busy_o) && c < 400) begin
      if (v.inject && c == 5) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = '0;
        bus.length_i    = 5'd3;
      end else begin
        bus.start_i     = 1'b0;
        bus.length_i    = '0;
      end
      @(posedge clk); #1;
      c++;
      drive_ready(v.mode, c);
      if (v.mode == 0 && v.len != 0 && c == 2) check("latency_e2", 32'(bus.valid_o), 32'h0);
      if (v.mode == 0 && v.len != 0 && c == 3) check("latency_e3", 32'(bus.valid_o), 32'h1);
    end
    bus.start_i = 1'b0;
    if (c >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_timeout: got %0d words left, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("beat_count", beat_cnt, v.exp_beats);
    if (v.exp_beats > 0) begin
      check("first_word", 32'(first_data), 32'(v.exp_first));
      check("final_word", 32'(final_data), 32'(v.exp_final));
    end
    if (v.mode == 0 && v.exp_beats > 0)
      check("back_to_back", last_cyc - first_cyc, v.exp_beats - 1);
    check("idle_after", 32'({bus.valid_o, bus.busy_o}), 32'h0);
    bus.ready_i = 1'b1;
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    int c;
    vecs[0] = '{base: 4'd3,  len: 5'd4,  mode: 0, inject: 1'b0, exp_first: 8'hA3, exp_final: 8'hA6, exp_beats: 4};
    vecs[1] = '{base: 4'd14, len: 5'd4,  mode: 0, inject: 1'b0, exp_first: 8'hAE, exp_final: 8'hA1, exp_beats: 4};
    vecs[2] = '{base: 4'd0,  len: 5'd6,  mode: 1, inject: 1'b0, exp_first: 8'hA0, exp_final: 8'hA5, exp_beats: 6};
    vecs[3] = '{base: 4'd7,  len: 5'd0,  mode: 0, inject: 1'b0, exp_first: 8'h00, exp_final: 8'h00, exp_beats: 0};
    vecs[4] = '{base: 4'd5,  len: 5'd16, mode: 0, inject: 1'b1, exp_first: 8'hA5, exp_final: 8'hA4, exp_beats: 16};
    vecs[5] = '{base: 4'd15, len: 5'd1,  mode: 1, inject: 1'b0, exp_first: 8'hAF, exp_final: 8'hAF, exp_beats: 1};
    post    = '{base: 4'd9,  len: 5'd3,  mode: 0, inject: 1'b0, exp_first: 8'hA9, exp_final: 8'hAB, exp_beats: 3};

    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.length_i    = '0;
    bus.ready_i     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          32'({bus.rom_addr_o, bus.valid_o, bus.last_o, bus.busy_o, bus.done_o, bus.data_o}), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Reset while the consumer stalls a partly buffered burst.
    push_expected(4'd2, 5'd8);
    beat_cnt    = 0;
    done_cnt    = 0;
    bus.ready_i = 1'b0;
    start_cmd(4'd2, 5'd8);
    c = 0;
    while (!bus.valid_o && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("stall_valid_rise", c, 3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_burst",
          32'({bus.valid_o, bus.busy_o, bus.rom_addr_o, bus.done_o}), 32'h0);
    exp_q.delete();
    rst         = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, 0);
    check("no_beat_after_rst", beat_cnt, 0);

    run_burst(post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
